// File: rtl/hp_vpu_lut_loader.sv
// Runtime writer for the VPU nonlinear-function LUT RAM: start command + word stream -> registered RAM writes.
// Optional feature: define LUT_LOAD_CHECKSUM_EN to require a trailing mod-2^16 checksum word per load.
module hp_vpu_lut_loader #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8,
    parameter int SEL_W  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [SEL_W-1:0]       func_sel_i,
    input  logic [IDX_W-1:0]       base_idx_i,
    input  logic [IDX_W:0]         count_i,
    input  logic                   abort_i,
    input  logic                   data_valid_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   data_ready_o,
    output logic                   lut_we_o,
    output logic [SEL_W+IDX_W-1:0] lut_waddr_o,
    output logic [DATA_W-1:0]      lut_wdata_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);
    localparam logic [IDX_W:0] MAX_CNT  = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] LAST_CNT = {{IDX_W{1'b0}}, 1'b1};

`ifdef LUT_LOAD_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
    logic [DATA_W-1:0] sum;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t           state;
    logic [SEL_W-1:0] bank;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   remaining;
    logic             xfer;
    logic             cnt_ok;

    assign xfer   = data_valid_i && data_ready_o;
    assign cnt_ok = (count_i != '0) && (count_i <= MAX_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            bank         <= '0;
            idx          <= '0;
            remaining    <= '0;
            data_ready_o <= 1'b0;
            lut_we_o     <= 1'b0;
            lut_waddr_o  <= '0;
            lut_wdata_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
`ifdef LUT_LOAD_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            lut_we_o <= 1'b0;
            // The pulse trails the DONE state by a cycle so it lands after the final write.
            done_o   <= (state == DONE);

            // A data transfer is always committed, even when abort_i arrives with it.
            if (xfer && state == LOAD) begin
                lut_we_o    <= 1'b1;
                lut_waddr_o <= {bank, idx};
                lut_wdata_o <= data_i;
                idx         <= idx + 1'b1;
                remaining   <= remaining - 1'b1;
`ifdef LUT_LOAD_CHECKSUM_EN
                sum         <= sum + data_i;
`endif
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (cnt_ok) begin
                            bank         <= func_sel_i;
                            idx          <= base_idx_i;
                            remaining    <= count_i;
                            err_o        <= 1'b0;
                            data_ready_o <= 1'b1;
                            busy_o       <= 1'b1;
                            state        <= LOAD;
`ifdef LUT_LOAD_CHECKSUM_EN
                            sum          <= '0;
`endif
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        err_o        <= 1'b1;
                        data_ready_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end else if (xfer && remaining == LAST_CNT) begin
`ifdef LUT_LOAD_CHECKSUM_EN
                        state        <= CHECK;
`else
                        // busy stays up through DONE while the last write issues.
                        data_ready_o <= 1'b0;
                        state        <= DONE;
`endif
                    end
                end
`ifdef LUT_LOAD_CHECKSUM_EN
                CHECK: begin
                    if (abort_i) begin
                        err_o        <= 1'b1;
                        data_ready_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end else if (xfer) begin
                        if (data_i != sum) err_o <= 1'b1;
                        data_ready_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state        <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    data_ready_o <= 1'b0;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hp_vpu_lut_loader.sv
// Directed bench for hp_vpu_lut_loader: write scoreboard plus state/flag checks per scenario.
module tb_hp_vpu_lut_loader;
    logic        clk = 1'b0;
    logic        rst, start, abort, data_valid;
    logic [1:0]  func_sel;
    logic [7:0]  base_idx;
    logic [8:0]  count;
    logic [15:0] data;
    logic        data_ready, lut_we, busy, done, err;
    logic [9:0]  lut_waddr;
    logic [15:0] lut_wdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_writes = 0, n_done = 0, last_we_cyc = 0, done_cyc = 0;
    logic [9:0]  last_waddr = '0;
    logic [25:0] sb[$];
    logic [25:0] exp_wr;

    logic [1:0]  m_bank;
    logic [7:0]  m_idx;
    logic [15:0] m_sum;

    hp_vpu_lut_loader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .func_sel_i(func_sel),
        .base_idx_i(base_idx), .count_i(count), .abort_i(abort),
        .data_valid_i(data_valid), .data_i(data), .data_ready_o(data_ready),
        .lut_we_o(lut_we), .lut_waddr_o(lut_waddr), .lut_wdata_o(lut_wdata),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lut_we === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $error("FAIL wr_unexpected: got addr=%0h data=%0h want no write", lut_waddr, lut_wdata);
            end else begin
                exp_wr = sb.pop_front();
                assert ({lut_waddr, lut_wdata} === exp_wr) else begin
                    bad++;
                    $error("FAIL wr_data: got addr=%0h data=%0h want addr=%0h data=%0h",
                           lut_waddr, lut_wdata, exp_wr[25:16], exp_wr[15:0]);
                end
            end
            n_writes++;
            last_we_cyc = cyc;
            last_waddr  = lut_waddr;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] sel, input logic [7:0] base, input logic [8:0] cnt);
        start = 1'b1; func_sel = sel; base_idx = base; count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input int gap, input bit is_data);
        data_valid = 1'b0;
        repeat (gap) begin
            check("ready_hold", {31'd0, data_ready}, 32'd1);
            tick();
        end
        check("ready", {31'd0, data_ready}, 32'd1);
        data_valid = 1'b1;
        data = w;
        if (is_data) begin
            sb.push_back({m_bank, m_idx, w});
            m_idx = m_idx + 8'd1;
            m_sum = m_sum + w;
        end
        tick();
        data_valid = 1'b0;
    endtask

    task automatic begin_model(input logic [1:0] sel, input logic [7:0] base);
        m_bank = sel; m_idx = base; m_sum = '0;
    endtask

    // Trailing checksum word, only when the loader expects one.
    task automatic finish_load();
`ifdef LUT_LOAD_CHECKSUM_EN
        send(m_sum, 0, 1'b0);
`endif
    endtask

    initial begin
        int w0, d0;
        logic [15:0] wv [4];
        rst = 1'b1; start = 0; abort = 0; data_valid = 0;
        func_sel = 0; base_idx = 0; count = 0; data = 0;
        m_bank = 0; m_idx = 0; m_sum = 0;

        // Reset state
        tick(); tick();
        check("rst_ready", {31'd0, data_ready}, 0);
        check("rst_we",    {31'd0, lut_we}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_done",  {31'd0, done}, 0);
        check("rst_err",   {31'd0, err}, 0);
        check("rst_waddr", {22'd0, lut_waddr}, 0);
        check("rst_wdata", {16'd0, lut_wdata}, 0);
        rst = 1'b0;
        tick();

        // Full bank, back-to-back
        d0 = n_done; w0 = n_writes;
        do_start(2'd2, 8'h00, 9'd256);
        begin_model(2'd2, 8'h00);
        for (int i = 0; i < 256; i++) send(16'(i), 0, 1'b1);
        finish_load();
        check("t1_busy_in_load_end", 32'(busy === 1'b1 || done === 1'b1 || lut_we === 1'b1), 1);
        tick(); tick(); tick();
        check("t1_writes", 32'(n_writes - w0), 256);
        check("t1_done",   32'(n_done - d0), 1);
`ifdef LUT_LOAD_CHECKSUM_EN
        check("t1_done_after_we", 32'(done_cyc > last_we_cyc), 1);
`else
        check("t1_done_lat", 32'(done_cyc), 32'(last_we_cyc + 1));
`endif
        check("t1_last_addr", {22'd0, last_waddr}, 32'h2FF);
        check("t1_err",  {31'd0, err}, 0);
        check("t1_busy", {31'd0, busy}, 0);
        check("t1_sb",   32'(sb.size()), 0);

        // Index wrap with random valid gaps
        wv[0] = 16'hA1A1; wv[1] = 16'hB2B2; wv[2] = 16'hC3C3; wv[3] = 16'hD4D4;
        w0 = n_writes;
        do_start(2'd1, 8'hFE, 9'd4);
        begin_model(2'd1, 8'hFE);
        for (int i = 0; i < 4; i++) send(wv[i], int'($urandom_range(3, 0)), 1'b1);
        finish_load();
        tick(); tick(); tick();
        check("t2_writes", 32'(n_writes - w0), 4);
        check("t2_last_addr", {22'd0, last_waddr}, 32'h101);
        check("t2_sb", 32'(sb.size()), 0);

        // Invalid counts, err clearing
        w0 = n_writes; d0 = n_done;
        do_start(2'd0, 8'h00, 9'd0);
        check("t3_err_cnt0",   {31'd0, err}, 1);
        check("t3_busy_cnt0",  {31'd0, busy}, 0);
        check("t3_ready_cnt0", {31'd0, data_ready}, 0);
        tick(); tick(); tick();
        check("t3_no_wr",   32'(n_writes - w0), 0);
        check("t3_no_done", 32'(n_done - d0), 0);
        do_start(2'd0, 8'hFF, 9'd1);
        begin_model(2'd0, 8'hFF);
        check("t3_err_clr", {31'd0, err}, 0);
        check("t3_busy",    {31'd0, busy}, 1);
        send(16'h5A5A, 0, 1'b1);
        finish_load();
        tick(); tick(); tick();
        check("t3_one_wr", 32'(n_writes - w0), 1);
        check("t3_last_addr", {22'd0, last_waddr}, 32'h0FF);
        w0 = n_writes;
        do_start(2'd0, 8'h00, 9'd257);
        check("t3_err_257",  {31'd0, err}, 1);
        check("t3_busy_257", {31'd0, busy}, 0);
        tick(); tick(); tick();
        check("t3_no_wr_257", 32'(n_writes - w0), 0);

        // Abort after 3 of 10, start while busy ignored
        w0 = n_writes; d0 = n_done;
        do_start(2'd3, 8'h10, 9'd10);
        begin_model(2'd3, 8'h10);
        send(16'h1111, 0, 1'b1);
        send(16'h2222, 1, 1'b1);
        do_start(2'd0, 8'h00, 9'd5);
        check("t4_busy_after_start", {31'd0, busy}, 1);
        send(16'h3333, 0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_ready", {31'd0, data_ready}, 0);
        check("t4_busy",  {31'd0, busy}, 0);
        check("t4_err",   {31'd0, err}, 1);
        tick(); tick(); tick(); tick();
        check("t4_writes", 32'(n_writes - w0), 3);
        check("t4_no_done", 32'(n_done - d0), 0);
        check("t4_last_addr", {22'd0, last_waddr}, 32'h312);
        check("t4_sb", 32'(sb.size()), 0);

`ifdef LUT_LOAD_CHECKSUM_EN
        // Checksum match and mismatch
        w0 = n_writes; d0 = n_done;
        do_start(2'd0, 8'h20, 9'd2);
        begin_model(2'd0, 8'h20);
        send(16'h8000, 0, 1'b1);
        send(16'h8001, 0, 1'b1);
        send(16'h0001, 0, 1'b0);
        tick(); tick(); tick();
        check("t5_writes", 32'(n_writes - w0), 2);
        check("t5_err_ok", {31'd0, err}, 0);
        check("t5_done_ok", 32'(n_done - d0), 1);
        d0 = n_done;
        do_start(2'd0, 8'h20, 9'd2);
        begin_model(2'd0, 8'h20);
        send(16'h8000, 0, 1'b1);
        send(16'h8001, 0, 1'b1);
        send(16'h0002, 0, 1'b0);
        tick(); tick(); tick();
        check("t5_err_bad", {31'd0, err}, 1);
        check("t5_done_bad", 32'(n_done - d0), 1);
`endif

        // Reset mid-load, then a clean load
        do_start(2'd0, 8'h40, 9'd8);
        begin_model(2'd0, 8'h40);
        send(16'h0A0A, 0, 1'b1);
        send(16'h0B0B, 0, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_ready", {31'd0, data_ready}, 0);
        check("t6_we",    {31'd0, lut_we}, 0);
        check("t6_busy",  {31'd0, busy}, 0);
        check("t6_done",  {31'd0, done}, 0);
        check("t6_err",   {31'd0, err}, 0);
        check("t6_waddr", {22'd0, lut_waddr}, 0);
        check("t6_wdata", {16'd0, lut_wdata}, 0);
        rst = 1'b0;
        tick();
        w0 = n_writes; d0 = n_done;
        do_start(2'd2, 8'h80, 9'd2);
        begin_model(2'd2, 8'h80);
        send(16'hCAFE, 0, 1'b1);
        send(16'hBEEF, 0, 1'b1);
        finish_load();
        tick(); tick(); tick();
        check("t6_writes", 32'(n_writes - w0), 2);
        check("t6_last_addr", {22'd0, last_waddr}, 32'h281);
        check("t6_done_cnt", 32'(n_done - d0), 1);
        check("t6_sb", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
